// File: rtl/bus_pkg.sv
// Shared encodings for the IFU/LSU memory bus arbiter: FSM states, owner ids, default widths.
package bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between IFU and LSU; zero latency, no state.
// Fixed priority favours LSU; round-robin hands a tie to whoever was not served last.
module arb_pick
  import bus_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic   ifu_valid_i,
  input  logic   lsu_valid_i,
  input  owner_e last_served_i,
  output owner_e winner_o
);

  always_comb begin
    winner_o = OWN_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
      if (ROUND_ROBIN) begin
        winner_o = (last_served_i == OWN_IFU) ? OWN_LSU : OWN_IFU;
      end else begin
        winner_o = OWN_LSU;
      end
    end else if (lsu_valid_i) begin
      winner_o = OWN_LSU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory slave between IFU and LSU, one transaction in flight; >=3 cycles per transaction.
// Owner is locked from grant until its response handshake; every channel is valid/ready backpressured.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rsp_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  owner_e winner;
  logic   rsp_rdy;

  arb_pick #(
    .ROUND_ROBIN (ROUND_ROBIN != 0)
  ) u_pick (
    .ifu_valid_i   (ifu_req_valid),
    .lsu_valid_i   (lsu_req_valid),
    .last_served_i (last_q),
    .winner_o      (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_IFU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    rsp_rdy       = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_rdata = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    mem_rsp_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Requests are only sampled here, so a waiting master never bypasses the response cycle.
        if (ifu_req_valid || lsu_req_valid) begin
          owner_d = winner;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (owner_q == OWN_LSU) begin
          mem_req_addr  = lsu_req_addr;
          mem_req_wen   = lsu_req_wen;
          mem_req_wdata = lsu_req_wdata;
          mem_req_wmask = lsu_req_wmask;
          lsu_req_ready = mem_req_ready;
        end else begin
          mem_req_addr  = ifu_req_addr;
          ifu_req_ready = mem_req_ready;
        end
        if (mem_req_ready) begin
          state_d = ST_RSP;
          last_d  = owner_q;
        end
      end

      ST_RSP: begin
        if (owner_q == OWN_LSU) begin
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rsp_rdata = mem_rsp_rdata;
          rsp_rdy       = lsu_rsp_ready;
        end else begin
          ifu_rsp_valid = mem_rsp_valid;
          ifu_rsp_rdata = mem_rsp_rdata;
          rsp_rdy       = ifu_rsp_ready;
        end
        mem_rsp_ready = rsp_rdy;
        if (mem_rsp_valid && rsp_rdy) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A slave response with no transaction awaiting it is dropped by the arbiter.
  rsp_only_in_rsp_state: assert property (
    @(posedge clk) disable iff (!rst) mem_rsp_valid |-> (state_q == ST_RSP)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench: instance 0 fixed priority, instance 1 round-robin, each with its own masters, slave and model.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } lreq_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err = 0;
  int   done_cnt [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_default(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : ~a;
  endfunction

  task automatic chk(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL i%0d %s @%0t: got 0x%0h want 0x%0h", inst, name, $time, act, exp);
    end
  endtask

  task automatic wait_done(input int inst, input int n);
    for (int c = 0; c < 400; c++) begin
      if (done_cnt[inst] >= n) break;
      @(negedge clk);
    end
    chk(inst, "done_count", done_cnt[inst], n);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_h
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_addr, ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic [3:0]  mem_req_wmask;

    logic [31:0] ifu_q [$];
    lreq_t       lsu_q [$];
    lreq_t       req_snap [$];
    int          gnt_log [$];
    int          gnt_cyc [$];
    int          rsp_cyc [$];
    logic [31:0] rsp_dat [$];
    logic [31:0] smem [logic [31:0]];
    int          ifu_hold = 0, lsu_hold = 0, s_stall = 0;
    int          stall_cnt = 0, mrr_zero_cnt = 0, lsu_rdy_cnt = 0;
    int          cyc = 0, m_phase = 0, m_owner = 0, m_last = 0;
    logic        ifu_req_hs = 0, lsu_req_hs = 0, mem_req_hs = 0, mem_rsp_hs = 0;
    logic        ifu_rsp_stall = 0, lsu_rsp_stall = 0;
    lreq_t       cap;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(g)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
    );

    // IFU master: presents queued fetches in order, optionally stalls its response channel.
    initial begin
      ifu_req_valid = 0; ifu_req_addr = '0; ifu_rsp_ready = 0;
      forever begin
        @(posedge clk); #1;
        if (!rst) begin
          ifu_q.delete(); ifu_hold = 0;
          ifu_req_valid = 0; ifu_req_addr = '0; ifu_rsp_ready = 1;
        end else begin
          if (ifu_req_hs && ifu_q.size() > 0) void'(ifu_q.pop_front());
          if (ifu_rsp_stall && ifu_hold > 0) ifu_hold--;
          ifu_req_valid = (ifu_q.size() > 0);
          ifu_req_addr  = (ifu_q.size() > 0) ? ifu_q[0] : 32'h0;
          ifu_rsp_ready = (ifu_hold == 0);
        end
      end
    end

    // LSU master
    initial begin
      lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
      lsu_rsp_ready = 0;
      forever begin
        @(posedge clk); #1;
        if (!rst) begin
          lsu_q.delete(); lsu_hold = 0;
          lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
          lsu_rsp_ready = 1;
        end else begin
          if (lsu_req_hs && lsu_q.size() > 0) void'(lsu_q.pop_front());
          if (lsu_rsp_stall && lsu_hold > 0) lsu_hold--;
          lsu_req_valid = (lsu_q.size() > 0);
          if (lsu_q.size() > 0) begin
            lsu_req_addr = lsu_q[0].addr; lsu_req_wen = lsu_q[0].wen;
            lsu_req_wdata = lsu_q[0].wdata; lsu_req_wmask = lsu_q[0].wmask;
          end else begin
            lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
          end
          lsu_rsp_ready = (lsu_hold == 0);
        end
      end
    end

    // Slave: byte-masked memory, s_stall wait cycles before accepting, response one cycle after accept.
    initial begin
      logic        busy;
      logic [31:0] cur;
      busy = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
      forever begin
        @(posedge clk); #1;
        if (!rst) begin
          busy = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
        end else begin
          if (mem_rsp_hs) begin
            busy = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
          end
          if (mem_req_hs) begin
            busy = 1; mem_rsp_valid = 1;
            cur = smem.exists(cap.addr) ? smem[cap.addr] : rd_default(cap.addr);
            if (cap.wen) begin
              for (int b = 0; b < 4; b++) if (cap.wmask[b]) cur[8*b +: 8] = cap.wdata[8*b +: 8];
              smem[cap.addr] = cur;
              mem_rsp_rdata = '0;
            end else begin
              mem_rsp_rdata = cur;
            end
          end
          mem_req_ready = !busy && (s_stall == 0);
        end
      end
    end

    // Transaction-level model: phase/owner per the arbitration rules, every output checked each cycle.
    initial begin
      logic own_lsu, req_ph, rsp_ph, o_rdy;
      forever begin
        @(negedge clk);
        if (!rst) begin
          m_phase = 0; m_owner = 0; m_last = 0;
          ifu_req_hs = 0; lsu_req_hs = 0; mem_req_hs = 0; mem_rsp_hs = 0;
          ifu_rsp_stall = 0; lsu_rsp_stall = 0;
        end else begin
          cyc++;
          own_lsu = (m_owner == 1);
          req_ph  = (m_phase == 1);
          rsp_ph  = (m_phase == 2);
          o_rdy   = own_lsu ? lsu_rsp_ready : ifu_rsp_ready;
          if (req_ph) begin
            chk(g, "mem_req_addr", mem_req_addr, own_lsu ? lsu_req_addr : ifu_req_addr);
            chk(g, "mem_req_wen", mem_req_wen, own_lsu ? lsu_req_wen : 1'b0);
            chk(g, "mem_req_wdata", mem_req_wdata, own_lsu ? lsu_req_wdata : 32'h0);
            chk(g, "mem_req_wmask", mem_req_wmask, own_lsu ? lsu_req_wmask : 4'h0);
          end
          chk(g, "mem_req_valid", mem_req_valid, req_ph);
          chk(g, "ifu_req_ready", ifu_req_ready, (req_ph && !own_lsu) ? mem_req_ready : 1'b0);
          chk(g, "lsu_req_ready", lsu_req_ready, (req_ph && own_lsu) ? mem_req_ready : 1'b0);
          chk(g, "mem_rsp_ready", mem_rsp_ready, rsp_ph ? o_rdy : 1'b0);
          chk(g, "ifu_rsp_valid", ifu_rsp_valid, (rsp_ph && !own_lsu) ? mem_rsp_valid : 1'b0);
          chk(g, "ifu_rsp_rdata", ifu_rsp_rdata, (rsp_ph && !own_lsu) ? mem_rsp_rdata : 32'h0);
          chk(g, "lsu_rsp_valid", lsu_rsp_valid, (rsp_ph && own_lsu) ? mem_rsp_valid : 1'b0);
          chk(g, "lsu_rsp_rdata", lsu_rsp_rdata, (rsp_ph && own_lsu) ? mem_rsp_rdata : 32'h0);

          ifu_req_hs    = ifu_req_valid && ifu_req_ready;
          lsu_req_hs    = lsu_req_valid && lsu_req_ready;
          mem_req_hs    = mem_req_valid && mem_req_ready;
          mem_rsp_hs    = mem_rsp_valid && mem_rsp_ready;
          ifu_rsp_stall = ifu_rsp_valid && !ifu_rsp_ready;
          lsu_rsp_stall = lsu_rsp_valid && !lsu_rsp_ready;
          if (mem_req_valid && !mem_req_ready && s_stall > 0) s_stall--;
          if (mem_req_hs) cap = '{mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask};
          if (mem_req_valid) req_snap.push_back('{mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask});
          if (lsu_req_ready) lsu_rdy_cnt++;
          if (ifu_rsp_stall || lsu_rsp_stall) begin
            stall_cnt++;
            if (!mem_rsp_ready) mrr_zero_cnt++;
          end

          case (m_phase)
            0: if (ifu_req_valid || lsu_req_valid) begin
                 if (ifu_req_valid && lsu_req_valid) m_owner = (g == 0) ? 1 : ((m_last == 0) ? 1 : 0);
                 else m_owner = lsu_req_valid ? 1 : 0;
                 m_phase = 1;
                 gnt_log.push_back(m_owner);
                 gnt_cyc.push_back(cyc);
               end
            1: if (mem_req_ready) begin
                 m_phase = 2;
                 m_last  = m_owner;
               end
            default: if (mem_rsp_valid && o_rdy) begin
                 m_phase = 0;
                 rsp_cyc.push_back(cyc);
                 rsp_dat.push_back(own_lsu ? lsu_rsp_rdata : ifu_rsp_rdata);
                 done_cnt[g]++;
               end
          endcase
        end
      end
    end
  end

  initial begin
    int          base, rbase, lat, first, d0;
    logic [31:0] got;
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk(0, "rst mem_req_valid", g_h[0].mem_req_valid, 0);
    chk(0, "rst mem_rsp_ready", g_h[0].mem_rsp_ready, 0);
    chk(0, "rst ifu_req_ready", g_h[0].ifu_req_ready, 0);
    chk(0, "rst lsu_req_ready", g_h[0].lsu_req_ready, 0);
    chk(0, "rst ifu_rsp_valid", g_h[0].ifu_rsp_valid, 0);
    chk(1, "rst lsu_rsp_valid", g_h[1].lsu_rsp_valid, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single IFU fetch, 0-wait slave: data on the 3rd cycle of valid.
    g_h[0].ifu_q.push_back(32'h8000_0000);
    lat = -1; first = -1; got = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (first < 0 && g_h[0].ifu_req_valid) first = c;
      if (first >= 0 && lat < 0 && g_h[0].ifu_rsp_valid) begin
        lat = c - first;
        got = g_h[0].ifu_rsp_rdata;
      end
    end
    chk(0, "ifu_rsp latency", lat, 2);
    chk(0, "ifu_rsp rdata", got, 32'h0000_0413);
    wait_done(0, 1);

    // Simultaneous requests under fixed priority.
    base = g_h[0].gnt_log.size(); rbase = g_h[0].rsp_cyc.size();
    g_h[0].lsu_q.push_back('{32'h8000_0100, 1'b0, 32'h0, 4'h0});
    g_h[0].ifu_q.push_back(32'h8000_0004);
    wait_done(0, 3);
    chk(0, "fp first grant", g_h[0].gnt_log[base], 1);
    chk(0, "fp second grant", g_h[0].gnt_log[base+1], 0);
    chk(0, "ifu grant follows lsu rsp", g_h[0].gnt_cyc[base+1], g_h[0].rsp_cyc[rbase] + 1);
    chk(0, "lsu read data", g_h[0].rsp_dat[rbase], 32'h7fff_feff);
    chk(0, "ifu read data", g_h[0].rsp_dat[rbase+1], 32'h7fff_fffb);

    // LSU write against a slave that stalls acceptance 3 cycles.
    g_h[0].s_stall = 3;
    @(negedge clk);
    g_h[0].req_snap.delete(); g_h[0].lsu_rdy_cnt = 0;
    g_h[0].lsu_q.push_back('{32'h8000_1000, 1'b1, 32'hdead_beef, 4'hf});
    wait_done(0, 4);
    chk(0, "stalled req cycles", g_h[0].req_snap.size(), 4);
    foreach (g_h[0].req_snap[i]) begin
      chk(0, "stalled addr", g_h[0].req_snap[i].addr, 32'h8000_1000);
      chk(0, "stalled wdata", g_h[0].req_snap[i].wdata, 32'hdead_beef);
      chk(0, "stalled wen/wmask", {g_h[0].req_snap[i].wen, g_h[0].req_snap[i].wmask}, 5'h1f);
    end
    chk(0, "lsu_req_ready pulses", g_h[0].lsu_rdy_cnt, 1);
    g_h[0].ifu_q.push_back(32'h8000_1000);
    wait_done(0, 5);
    chk(0, "readback full word", g_h[0].rsp_dat[4], 32'hdead_beef);
    g_h[0].lsu_q.push_back('{32'h8000_1000, 1'b1, 32'h1122_3344, 4'h3});
    wait_done(0, 6);
    g_h[0].lsu_q.push_back('{32'h8000_1000, 1'b0, 32'h0, 4'h0});
    wait_done(0, 7);
    chk(0, "readback low half", g_h[0].rsp_dat[6], 32'hdead_3344);

    // Owner stalls its response for 5 cycles while IFU waits.
    base = g_h[0].gnt_log.size(); rbase = g_h[0].rsp_cyc.size();
    g_h[0].stall_cnt = 0; g_h[0].mrr_zero_cnt = 0; g_h[0].lsu_hold = 5;
    g_h[0].lsu_q.push_back('{32'h8000_0200, 1'b0, 32'h0, 4'h0});
    for (int c = 0; c < 50; c++) begin
      if (g_h[0].gnt_log.size() > base) break;
      @(negedge clk);
    end
    g_h[0].ifu_q.push_back(32'h8000_0204);
    wait_done(0, 9);
    chk(0, "rsp stall cycles", g_h[0].stall_cnt, 5);
    chk(0, "mem_rsp_ready low in stall", g_h[0].mrr_zero_cnt, 5);
    chk(0, "stall first grant", g_h[0].gnt_log[base], 1);
    chk(0, "ifu waits for lsu rsp", g_h[0].gnt_cyc[base+1], g_h[0].rsp_cyc[rbase] + 1);

    // Reset while a response is pending.
    g_h[0].ifu_hold = 3;
    g_h[0].ifu_q.push_back(32'h8000_0300);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (g_h[0].ifu_rsp_valid) break;
    end
    chk(0, "pre-reset ifu_rsp_valid", g_h[0].ifu_rsp_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk(0, "async rst ifu_rsp_valid", g_h[0].ifu_rsp_valid, 0);
    chk(0, "async rst mem_rsp_ready", g_h[0].mem_rsp_ready, 0);
    chk(0, "async rst mem_req_valid", g_h[0].mem_req_valid, 0);
    chk(0, "async rst ifu_rsp_rdata", g_h[0].ifu_rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    d0 = done_cnt[0];
    g_h[0].ifu_q.push_back(32'h8000_0008);
    wait_done(0, d0 + 1);
    chk(0, "post-reset fetch", g_h[0].rsp_dat[g_h[0].rsp_dat.size()-1], 32'h7fff_fff7);

    // Round-robin instance: both masters held valid for four transactions.
    g_h[1].ifu_q.push_back(32'h8000_0010);
    g_h[1].ifu_q.push_back(32'h8000_0014);
    g_h[1].lsu_q.push_back('{32'h8000_0020, 1'b0, 32'h0, 4'h0});
    g_h[1].lsu_q.push_back('{32'h8000_0024, 1'b0, 32'h0, 4'h0});
    wait_done(1, 4);
    chk(1, "rr grant 0", g_h[1].gnt_log[0], 1);
    chk(1, "rr grant 1", g_h[1].gnt_log[1], 0);
    chk(1, "rr grant 2", g_h[1].gnt_log[2], 1);
    chk(1, "rr grant 3", g_h[1].gnt_log[3], 0);
    chk(1, "rr first data", g_h[1].rsp_dat[0], 32'h7fff_ffdf);
    chk(1, "rr second data", g_h[1].rsp_dat[1], 32'h7fff_ffef);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
